// File: rtl/sample_frame_pkg.sv
// Shared types and helpers for the sample frame assembler.
// Holds the fill-state encoding, the index width rule and channel-count clamping.
package sample_frame_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } fill_state_e;

  // Width that holds 0..nch inclusive, never narrower than one bit.
  function automatic int cw_width(input int nch);
    int w;
    w = $clog2(nch + 1);
    return (w < 1) ? 1 : w;
  endfunction

  // Out-of-range requests (0 or above the maximum) fall back to a full frame.
  function automatic int clamp_channels(input int active, input int nch);
    return (active == 0 || active > nch) ? nch : active;
  endfunction

endpackage

// File: rtl/frame_out_reg.sv
// Output holding register: one frame word with valid/ready and a publish counter.
// Loaded frame visible next cycle; accepts a new load while the old one is taken (no bubble).
module frame_out_reg #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_vld,
  input  logic [WIDTH-1:0] load_dat,
  input  logic             frame_ready,
  output logic [WIDTH-1:0] frame_data,
  output logic             frame_valid,
  output logic [15:0]      frame_count,
  output logic             can_load
);

  assign can_load = !frame_valid || frame_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      frame_data  <= '0;
      frame_valid <= 1'b0;
      frame_count <= '0;
    end else if (load_vld && can_load) begin
      frame_data  <= load_dat;
      frame_valid <= 1'b1;
      frame_count <= frame_count + 16'd1;
    end else if (frame_valid && frame_ready) begin
      frame_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/sample_frame_assembler.sv
// Assembles a channel-interleaved sample stream into parallel frames of up to NUM_CHANNELS.
// Frame published one cycle after its last sample; a completed frame is dropped (overrun) if the output is still held.
module sample_frame_assembler
  import sample_frame_pkg::*;
#(
  parameter int NUM_CHANNELS = 4,
  parameter int DATA_WIDTH   = 16,
  parameter bit AUTO_SYNC    = 1'b0,
  localparam int CW          = cw_width(NUM_CHANNELS)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [DATA_WIDTH-1:0]              sample_in,
  input  logic                               sample_wr,
  input  logic                               frame_sync,
  input  logic [CW-1:0]                      active_channels,
  input  logic                               frame_ready,
  input  logic                               clear_err,
  output logic [NUM_CHANNELS*DATA_WIDTH-1:0] frame_data,
  output logic                               frame_valid,
  output logic [15:0]                        frame_count,
  output logic                               sync_err,
  output logic                               overrun
);

  fill_state_e                        state, state_nxt;
  logic [CW-1:0]                      idx, idx_nxt;
  logic [CW-1:0]                      n_lat, n_nxt;
  logic [CW-1:0]                      wr_pos, n_cur;
  logic [DATA_WIDTH-1:0]              bank [NUM_CHANNELS];
  logic                               accept, start, mid_sync, complete;
  logic                               can_load;
  logic [NUM_CHANNELS*DATA_WIDTH-1:0] asm_dat;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= AUTO_SYNC ? FILL : IDLE;
      idx   <= '0;
      n_lat <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
      n_lat <= n_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    n_nxt     = n_lat;
    accept    = 1'b0;
    start     = 1'b0;
    mid_sync  = 1'b0;
    complete  = 1'b0;
    wr_pos    = idx;
    n_cur     = n_lat;

    case (state)
      IDLE: begin
        if (sample_wr && frame_sync) begin
          accept = 1'b1;
          start  = 1'b1;
        end
      end
      FILL: begin
        if (sample_wr) begin
          accept   = 1'b1;
          start    = frame_sync;
          mid_sync = frame_sync && (idx != '0);
        end
      end
      default: ;
    endcase

    // A sync restarts the frame at channel 0, abandoning any partial fill.
    if (start) wr_pos = '0;
    if (accept && wr_pos == '0)
      n_cur = CW'(clamp_channels(int'(active_channels), NUM_CHANNELS));

    if (accept) begin
      state_nxt = FILL;
      n_nxt     = n_cur;
      complete  = (wr_pos == n_cur - 1'b1);
      idx_nxt   = complete ? '0 : wr_pos + 1'b1;
    end
  end

  always_comb begin
    asm_dat = '0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      if (CW'(k) < n_cur)
        asm_dat[k*DATA_WIDTH +: DATA_WIDTH] = (CW'(k) == wr_pos) ? sample_in : bank[k];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CHANNELS; k++) bank[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CHANNELS; k++)
        if (accept && wr_pos == CW'(k)) bank[k] <= sample_in;
    end
  end

  // Set events take priority over clear_err in the same cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync_err <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (mid_sync)          sync_err <= 1'b1;
      else if (clear_err)    sync_err <= 1'b0;
      if (complete && !can_load) overrun <= 1'b1;
      else if (clear_err)        overrun <= 1'b0;
    end
  end

  frame_out_reg #(
    .WIDTH(NUM_CHANNELS*DATA_WIDTH)
  ) u_out (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_vld   (complete),
    .load_dat   (asm_dat),
    .frame_ready(frame_ready),
    .frame_data (frame_data),
    .frame_valid(frame_valid),
    .frame_count(frame_count),
    .can_load   (can_load)
  );

endmodule
